// File: rtl/id_exe_elastic_stage.sv
// ID->EXE elastic pipeline stage: a main register that drives the EXE side,
// backed by a one-entry skid register. This keeps full throughput while
// in_ready stays a pure function of registered state.
// Optional feature macro: ID_EXE_PERF_EN adds the stall_cnt and bubble_cnt
// performance counters. With the macro undefined, the datapath is unchanged.
module id_exe_elastic_stage #(
  parameter int CTRL_W   = 24,
  parameter int DATA_W   = 352,
  parameter bit CLR_CTRL = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data
`ifdef ID_EXE_PERF_EN
  ,
  output logic [31:0]       stall_cnt,
  output logic [31:0]       bubble_cnt
`endif
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_BUSY  = 2'd1,
    ST_FULL  = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [CTRL_W-1:0] main_ctrl_q, main_ctrl_d;
  logic [DATA_W-1:0] main_data_q, main_data_d;
  logic [CTRL_W-1:0] skid_ctrl_q, skid_ctrl_d;
  logic [DATA_W-1:0] skid_data_q, skid_data_d;
  logic              in_fire_s;
  logic              out_fire_s;

  // Handshake flags are decoded straight from the state register, so there is
  // no combinational path from out_ready to in_ready.
  assign out_valid  = (state_q != ST_EMPTY);
  assign in_ready   = (state_q != ST_FULL);
  assign in_fire_s  = in_valid & in_ready;
  assign out_fire_s = out_valid & out_ready;
  assign out_ctrl   = main_ctrl_q;
  assign out_data   = main_data_q;

  // Next-state and storage update.
  // Whenever the main slot empties, its control is zeroed so that a bubble is a NOP.
  always_comb begin
    state_d     = state_q;
    main_ctrl_d = main_ctrl_q;
    main_data_d = main_data_q;
    skid_ctrl_d = skid_ctrl_q;
    skid_data_d = skid_data_q;
    if (flush) begin
      state_d = ST_EMPTY;
      if (CLR_CTRL) begin
        main_ctrl_d = {CTRL_W{1'b0}};
      end else begin
        main_ctrl_d = main_ctrl_q;
      end
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (in_fire_s) begin
            state_d     = ST_BUSY;
            main_ctrl_d = in_ctrl;
            main_data_d = in_data;
          end else begin
            state_d = ST_EMPTY;
          end
        end
        ST_BUSY: begin
          if (in_fire_s && out_fire_s) begin
            main_ctrl_d = in_ctrl;
            main_data_d = in_data;
          end else if (in_fire_s) begin
            state_d     = ST_FULL;
            skid_ctrl_d = in_ctrl;
            skid_data_d = in_data;
          end else if (out_fire_s) begin
            state_d = ST_EMPTY;
            if (CLR_CTRL) begin
              main_ctrl_d = {CTRL_W{1'b0}};
            end else begin
              main_ctrl_d = main_ctrl_q;
            end
          end else begin
            state_d = ST_BUSY;
          end
        end
        ST_FULL: begin
          if (out_fire_s) begin
            state_d     = ST_BUSY;
            main_ctrl_d = skid_ctrl_q;
            main_data_d = skid_data_q;
          end else begin
            state_d = ST_FULL;
          end
        end
        default: begin
          state_d     = ST_EMPTY;
          main_ctrl_d = {CTRL_W{1'b0}};
        end
      endcase
    end
  end

  // State and storage registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_EMPTY;
      main_ctrl_q <= {CTRL_W{1'b0}};
      main_data_q <= {DATA_W{1'b0}};
      skid_ctrl_q <= {CTRL_W{1'b0}};
      skid_data_q <= {DATA_W{1'b0}};
    end else begin
      state_q     <= state_d;
      main_ctrl_q <= main_ctrl_d;
      main_data_q <= main_data_d;
      skid_ctrl_q <= skid_ctrl_d;
      skid_data_q <= skid_data_d;
    end
  end

`ifdef ID_EXE_PERF_EN
  logic [31:0] stall_cnt_q;
  logic [31:0] bubble_cnt_q;

  assign stall_cnt  = stall_cnt_q;
  assign bubble_cnt = bubble_cnt_q;

  // Saturating stall and bubble counters.
  // Only reset clears them; a flush leaves them unchanged.
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt_q  <= 32'd0;
      bubble_cnt_q <= 32'd0;
    end else begin
      if (out_valid && !out_ready && (stall_cnt_q != 32'hFFFF_FFFF)) begin
        stall_cnt_q <= stall_cnt_q + 32'd1;
      end
      if (!out_valid && (bubble_cnt_q != 32'hFFFF_FFFF)) begin
        bubble_cnt_q <= bubble_cnt_q + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_id_exe_elastic_stage.sv
// Scoreboard bench for id_exe_elastic_stage.
// Accepted inputs are queued as expected outputs.
// A negedge monitor pops the queue on every out_fire and compares the result.
module tb_id_exe_elastic_stage;
  localparam int CW = 24;
  localparam int DW = 352;

  logic          clk = 1'b0;
  logic          reset, flush, in_valid, out_ready;
  logic          in_ready, out_valid;
  logic [CW-1:0] in_ctrl, out_ctrl;
  logic [DW-1:0] in_data, out_data;
`ifdef ID_EXE_PERF_EN
  logic [31:0]   stall_cnt, bubble_cnt;
`endif

  int tests = 0;
  int fails = 0;
  logic [CW+DW-1:0] exp_q[$];

  id_exe_elastic_stage #(.CTRL_W(CW), .DATA_W(DW), .CLR_CTRL(1'b1)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_ctrl(in_ctrl), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_ctrl(out_ctrl), .out_data(out_data)
`ifdef ID_EXE_PERF_EN
    , .stall_cnt(stall_cnt), .bubble_cnt(bubble_cnt)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] dpat(input int i);
    logic [31:0] w;
    w = 32'hD0D0_0000 + 32'(i);
    return {11{w}};
  endfunction

  task automatic check(input string name, input logic [383:0] act, input logic [383:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: checks outputs against the scoreboard, then records new accepts.
  always @(negedge clk) begin
    logic [CW+DW-1:0] e;
    if (reset) begin
      exp_q.delete();
    end else begin
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_out: got ctrl %0h expected no output", out_ctrl);
        end else begin
          e = exp_q.pop_front();
          check("sb_ctrl", 384'(out_ctrl), 384'(e[CW+DW-1:DW]));
          check("sb_data", 384'(out_data), 384'(e[DW-1:0]));
        end
      end
      if (!out_valid) check("bubble_ctrl", 384'(out_ctrl), 384'd0);
      if (flush) exp_q.delete();
      else if (in_valid && in_ready) exp_q.push_back({in_ctrl, in_data});
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [CW-1:0] c, input logic [DW-1:0] d);
    in_valid = v;
    in_ctrl  = c;
    in_data  = d;
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0; out_ready = 1'b0;
    drive(1'b0, 24'd0, {DW{1'b0}});
    step(); step();
    reset = 1'b0;
    check("rst_out_valid", 384'(out_valid), 384'd0);
    check("rst_out_ctrl", 384'(out_ctrl), 384'd0);
    check("rst_out_data", 384'(out_data), 384'd0);
    check("rst_in_ready", 384'(in_ready), 384'd1);

    // Test 1: single transfer with a one-cycle latency.
    drive(1'b1, 24'h0000A5, dpat(0));
    out_ready = 1'b1;
    step();
    drive(1'b0, 24'd0, {DW{1'b0}});
    check("t1_valid", 384'(out_valid), 384'd1);
    check("t1_ctrl", 384'(out_ctrl), 384'h0000A5);
    check("t1_data", 384'(out_data), 384'(dpat(0)));
    step();
    check("t1_drained", 384'(out_valid), 384'd0);

    // Test 2: back-to-back stream of D0..D7.
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 24'(i + 1), dpat(i));
      step();
      check("t2_in_ready", 384'(in_ready), 384'd1);
      check("t2_valid", 384'(out_valid), 384'd1);
    end
    drive(1'b0, 24'd0, {DW{1'b0}});
    step(); step();
    check("t2_sb_empty", 384'(exp_q.size()), 384'd0);

    // Test 3: back-pressure fills the skid register, holds, then drains.
    out_ready = 1'b0;
    drive(1'b1, 24'h10, dpat(0));
    step();
    check("t3_busy_ready", 384'(in_ready), 384'd1);
    drive(1'b1, 24'h11, dpat(1));
    step();
    drive(1'b0, 24'd0, {DW{1'b0}});
    check("t3_full_ready", 384'(in_ready), 384'd0);
    for (int i = 0; i < 3; i++) begin
      step();
      check("t3_hold_data", 384'(out_data), 384'(dpat(0)));
      check("t3_hold_ctrl", 384'(out_ctrl), 384'h10);
      check("t3_hold_ready", 384'(in_ready), 384'd0);
    end
    out_ready = 1'b1;
    step();
    check("t3_second_data", 384'(out_data), 384'(dpat(1)));
    check("t3_ready_back", 384'(in_ready), 384'd1);
    step();
    check("t3_empty", 384'(out_valid), 384'd0);

    // Test 4: flush while FULL with D2 offered, then flush while BUSY with D3 offered.
    out_ready = 1'b0;
    drive(1'b1, 24'h20, dpat(0)); step();
    drive(1'b1, 24'h21, dpat(1)); step();
    drive(1'b1, 24'h22, dpat(2));
    flush = 1'b1;
    step();
    flush = 1'b0;
    drive(1'b0, 24'd0, {DW{1'b0}});
    check("t4_valid", 384'(out_valid), 384'd0);
    check("t4_ctrl", 384'(out_ctrl), 384'd0);
    check("t4_ready", 384'(in_ready), 384'd1);
    drive(1'b1, 24'h30, dpat(0)); step();
    drive(1'b1, 24'h33, dpat(3));
    flush = 1'b1;
    step();
    flush = 1'b0;
    drive(1'b0, 24'd0, {DW{1'b0}});
    check("t4b_valid", 384'(out_valid), 384'd0);
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("t4_no_ghost", 384'(out_valid), 384'd0);
    end

    // Test 5: reset while FULL.
    out_ready = 1'b0;
    drive(1'b1, 24'h40, dpat(4)); step();
    drive(1'b1, 24'h41, dpat(5)); step();
    drive(1'b0, 24'd0, {DW{1'b0}});
    check("t5_full", 384'(in_ready), 384'd0);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("t5_valid", 384'(out_valid), 384'd0);
    check("t5_ctrl", 384'(out_ctrl), 384'd0);
    check("t5_data", 384'(out_data), 384'd0);
    check("t5_ready", 384'(in_ready), 384'd1);

`ifdef ID_EXE_PERF_EN
    // Test 6: 3 empty cycles and 5 stalled cycles, then a flush.
    check("t6_rst_stall", 384'(stall_cnt), 384'd0);
    check("t6_rst_bubble", 384'(bubble_cnt), 384'd0);
    drive(1'b1, 24'h50, dpat(6)); step();
    drive(1'b0, 24'd0, {DW{1'b0}});
    repeat (5) step();
    out_ready = 1'b1; step();
    out_ready = 1'b0; step(); step();
    check("t6_stall", 384'(stall_cnt), 384'd5);
    check("t6_bubble", 384'(bubble_cnt), 384'd3);
    flush = 1'b1; step(); flush = 1'b0;
    check("t6_flush_stall", 384'(stall_cnt), 384'd5);
    check("t6_flush_bubble", 384'(bubble_cnt), 384'd4);
`endif

    step();
    check("final_sb_empty", 384'(exp_q.size()), 384'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
